// File: rtl/trigger_surround_cache_pkg.sv
// Shared definitions for the trigger-surround cache.
// - tsc_state_e : FSM state codes (IDLE..SEND_DONE), 4-bit so unused codes are representable.
// - TSC_DEPTH / TSC_PRE / TSC_TRIG_LEVEL : default window geometry and trigger threshold.
// - tsc_wrap_add : modulo-depth pointer arithmetic used by the ring buffer.
package trigger_surround_cache_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PRE_FILL  = 4'd1,
        ST_WAIT_TRIG = 4'd2,
        ST_POST_FILL = 4'd3,
        ST_CACHED    = 4'd4,
        ST_SEND_DONE = 4'd5
    } tsc_state_e;

    localparam int unsigned TSC_DEPTH      = 32;
    localparam int unsigned TSC_PRE        = 16;
    localparam logic [7:0]  TSC_TRIG_LEVEL = 8'd200;

    function automatic int unsigned tsc_wrap_add(input int unsigned p,
                                                 input int unsigned d,
                                                 input int unsigned depth);
        return (p + d) % depth;
    endfunction

endpackage

// File: rtl/trigger_surround_cache_if.sv
// Read-out handshake between the cache and its consumer.
// - req : consumer read request, one byte per rising edge
// - sbf : consumer send-buffer full, holds off byte issue
// - rdy : dat valid, held until req falls
// - dat : read-out byte
// - sd  : one-cycle send-done pulse
interface trigger_surround_cache_if;
    logic       req;
    logic       sbf;
    logic       rdy;
    logic [7:0] dat;
    logic       sd;

    modport master (output req, output sbf, input rdy, input dat, input sd);
    modport slave  (input req, input sbf, output rdy, output dat, output sd);
endinterface

// File: rtl/tsc_ring_buffer.sv
// DEPTH x 8 sample ring with wrapping write pointer, trigger-slot capture and
// a read pointer that starts at the oldest retained sample (trigger slot - PRE).
// Ports: clk, rst_n (async active-low), wr_clr (restart writing at slot 0),
// wr_en/wr_data (store one sample), mark_trig (remember current write slot),
// rd_load (point reader at oldest sample), rd_adv (step reader), rd_data (byte at reader).
module tsc_ring_buffer
    import trigger_surround_cache_pkg::*;
#(
    parameter int unsigned DEPTH = TSC_DEPTH,
    parameter int unsigned PRE   = TSC_PRE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_clr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       mark_trig,
    input  logic       rd_load,
    input  logic       rd_adv,
    output logic [7:0] rd_data
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] trig_slot;

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            trig_slot <= '0;
        end else begin
            if (wr_clr) begin
                wptr <= '0;
            end else if (wr_en) begin
                wptr <= AW'(tsc_wrap_add(32'(wptr), 1, DEPTH));
            end
            // The trigger sample is written in the same cycle, so its slot is wptr.
            if (mark_trig) begin
                trig_slot <= wptr;
            end
            if (rd_load) begin
                rptr <= AW'(tsc_wrap_add(32'(trig_slot), DEPTH - PRE, DEPTH));
            end else if (rd_adv) begin
                rptr <= AW'(tsc_wrap_add(32'(rptr), 1, DEPTH));
            end
        end
    end

    assign rd_data = mem[rptr];

endmodule

// File: rtl/trigger_surround_cache.sv
// Trigger-surround cache: free-running sawtooth ADC source, rising-threshold
// trigger, PRE/post window capture into a ring, and byte read-out over req/rdy.
// Ports: clk, reset (async active-low), start (begin capture, IDLE only),
// rd_if (slave side of req/sbf/rdy/dat/sd handshake), adc_data (current sample),
// trd (trigger seen), cd (window captured), trigtm (trigger timestamp),
// current_state (FSM code, zero-extended).
module trigger_surround_cache
    import trigger_surround_cache_pkg::*;
#(
    parameter int unsigned DEPTH      = TSC_DEPTH,
    parameter int unsigned PRE        = TSC_PRE,
    parameter logic [7:0]  TRIG_LEVEL = TSC_TRIG_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    trigger_surround_cache_if.slave rd_if,
    output logic [7:0]            adc_data,
    output logic                  trd,
    output logic                  cd,
    output logic [31:0]           trigtm,
    output logic [3:0]            current_state
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    tsc_state_e    state, next_state;
    logic [31:0]   cyc_cnt;
    logic [7:0]    prev_sample;
    logic [AW-1:0] fill_cnt;
    logic [CW-1:0] byte_cnt;
    logic          req_q, pending, rdy_r;
    logic [7:0]    dat_r, rd_data;
    logic          wr_en, wr_clr, mark_trig, rd_load, issue, trig_hit, req_rise;

    assign adc_data      = cyc_cnt[7:0];
    assign current_state = state;
    assign trig_hit      = (prev_sample < TRIG_LEVEL) && (adc_data >= TRIG_LEVEL);
    assign req_rise      = rd_if.req && !req_q;
    assign rd_if.rdy     = rdy_r;
    assign rd_if.dat     = dat_r;
    assign rd_if.sd      = (state == ST_SEND_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        wr_clr     = 1'b0;
        mark_trig  = 1'b0;
        rd_load    = 1'b0;
        issue      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    wr_clr     = 1'b1;
                    next_state = ST_PRE_FILL;
                end
            end
            ST_PRE_FILL: begin
                wr_en = 1'b1;
                if (fill_cnt == AW'(PRE - 1)) next_state = ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
                wr_en = 1'b1;
                if (trig_hit) begin
                    mark_trig  = 1'b1;
                    next_state = ST_POST_FILL;
                end
            end
            ST_POST_FILL: begin
                wr_en = 1'b1;
                if (fill_cnt == AW'(DEPTH - PRE - 2)) begin
                    rd_load    = 1'b1;
                    next_state = ST_CACHED;
                end
            end
            ST_CACHED: begin
                issue = pending && !rd_if.sbf && (byte_cnt < CW'(DEPTH));
                if ((byte_cnt == CW'(DEPTH)) && !rd_if.req) next_state = ST_SEND_DONE;
            end
            ST_SEND_DONE: next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt     <= '0;
            prev_sample <= '0;
            fill_cnt    <= '0;
        end else begin
            cyc_cnt     <= cyc_cnt + 32'd1;
            prev_sample <= adc_data;
            // Fill count restarts on every state change so PRE and POST share it.
            if (next_state != state) fill_cnt <= '0;
            else if (wr_en)          fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q    <= 1'b0;
            pending  <= 1'b0;
            rdy_r    <= 1'b0;
            dat_r    <= '0;
            byte_cnt <= '0;
        end else begin
            req_q <= rd_if.req;
            if (state != ST_CACHED) begin
                pending  <= 1'b0;
                rdy_r    <= 1'b0;
                byte_cnt <= '0;
            end else begin
                pending <= (pending && !issue) || req_rise;
                if (issue) begin
                    dat_r    <= rd_data;
                    rdy_r    <= 1'b1;
                    byte_cnt <= byte_cnt + 1'b1;
                end else if (!rd_if.req) begin
                    rdy_r <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trd    <= 1'b0;
            cd     <= 1'b0;
            trigtm <= '0;
        end else begin
            if (mark_trig) begin
                trd    <= 1'b1;
                trigtm <= cyc_cnt;
            end
            if (rd_load) cd <= 1'b1;
            if (state == ST_SEND_DONE) begin
                trd <= 1'b0;
                cd  <= 1'b0;
            end
        end
    end

    tsc_ring_buffer #(
        .DEPTH (DEPTH),
        .PRE   (PRE)
    ) u_ring (
        .clk       (clk),
        .rst_n     (reset),
        .wr_clr    (wr_clr),
        .wr_en     (wr_en),
        .wr_data   (adc_data),
        .mark_trig (mark_trig),
        .rd_load   (rd_load),
        .rd_adv    (issue),
        .rd_data   (rd_data)
    );

endmodule

// File: tb/tb_trigger_surround_cache.sv
// Scoreboard bench for trigger_surround_cache: stimulus pushes expected trigger
// times and read-out bytes, a negedge monitor pops and compares them.
module tb_trigger_surround_cache;
    import trigger_surround_cache_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  adc_data;
    logic        trd, cd;
    logic [31:0] trigtm;
    logic [3:0]  current_state;

    trigger_surround_cache_if rd_if ();

    trigger_surround_cache dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rd_if         (rd_if.slave),
        .adc_data      (adc_data),
        .trd           (trd),
        .cd            (cd),
        .trigtm        (trigtm),
        .current_state (current_state)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned sd_count = 0;
    int unsigned exp_sd   = 0;
    logic [31:0] tb_cyc;
    logic [31:0] last_trig = '0;
    logic [7:0]  exp_q [$];
    logic [31:0] trig_q [$];
    logic        rdy_p = 1'b0, trd_p = 1'b0, cd_p = 1'b0, sd_p = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference cycle count: zero at reset, +1 per clock.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    // First cycle at or after s+17 (pre-fill done) where the sample rises across 200.
    function automatic logic [31:0] trig_time(input logic [31:0] s);
        logic [31:0] t;
        logic [7:0]  cur, prv;
        t = s + 32'd17;
        for (int i = 0; i < 300; i++) begin
            cur = t[7:0];
            prv = cur - 8'd1;
            if (prv < 8'd200 && cur >= 8'd200) break;
            t = t + 32'd1;
        end
        return t;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            rdy_p <= 1'b0; trd_p <= 1'b0; cd_p <= 1'b0; sd_p <= 1'b0;
        end else begin
            check("adc_data", 64'(adc_data), 64'(tb_cyc[7:0]));
            if (rd_if.rdy && !rdy_p) begin
                if (exp_q.size() == 0) check("unexpected_byte", 64'(rd_if.dat), 64'hFFFF);
                else begin
                    check("dat", 64'(rd_if.dat), 64'(exp_q[0]));
                    exp_q.delete(0);
                end
            end
            if (trd && !trd_p) begin
                if (trig_q.size() == 0) check("unexpected_trigger", 64'(trigtm), 64'hFFFF);
                else begin
                    check("trigtm", 64'(trigtm), 64'(trig_q[0]));
                    check("trigger_cycle", 64'(tb_cyc), 64'(trig_q[0] + 32'd1));
                    last_trig <= trig_q[0];
                    trig_q.delete(0);
                end
            end
            if (cd && !cd_p) begin
                check("cd_cycle", 64'(tb_cyc), 64'(last_trig + 32'd16));
                check("cd_state", 64'(current_state), 64'(ST_CACHED));
                check("cd_with_trd", 64'(trd), 64'd1);
            end
            if (rd_if.sd) begin
                sd_count <= sd_count + 1;
                check("sd_single_cycle", 64'(sd_p), 64'd0);
                check("sd_after_all_bytes", 64'(exp_q.size()), 64'd0);
                check("sd_flags_held", 64'({trd, cd}), 64'd3);
            end
            rdy_p <= rd_if.rdy; trd_p <= trd; cd_p <= cd; sd_p <= rd_if.sd;
        end
    end

    task automatic run_capture(input logic [7:0] start_mod);
        logic [31:0] s, t;
        int unsigned n;
        n = 0;
        while (tb_cyc[7:0] != start_mod && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("start_align", 64'(tb_cyc[7:0]), 64'(start_mod));
        check("idle_before_start", 64'(current_state), 64'(ST_IDLE));
        s = tb_cyc;
        t = trig_time(s);
        trig_q.push_back(t);
        for (int k = 0; k < 32; k++) exp_q.push_back(8'(t - 32'd16 + 32'(k)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("state_pre_fill", 64'(current_state), 64'(ST_PRE_FILL));
        repeat (16) @(negedge clk);
        check("state_wait_trig", 64'(current_state), 64'(ST_WAIT_TRIG));
        n = 0;
        while (!cd && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("cd_timeout", 64'(cd), 64'd1);
        check("state_cached", 64'(current_state), 64'(ST_CACHED));
    endtask

    task automatic read_byte(input int unsigned hold);
        int unsigned n;
        @(negedge clk);
        rd_if.req = 1'b1;
        rd_if.sbf = (hold != 0);
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            check("rdy_blocked_by_sbf", 64'(rd_if.rdy), 64'd0);
        end
        rd_if.sbf = 1'b0;
        n = 0;
        while (!rd_if.rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rdy_timeout", 64'(rd_if.rdy), 64'd1);
        repeat (3) @(negedge clk);
        check("rdy_held", 64'(rd_if.rdy), 64'd1);
        rd_if.req = 1'b0;
        repeat (5) @(negedge clk);
        check("rdy_dropped", 64'(rd_if.rdy), 64'd0);
    endtask

    task automatic read_n(input int unsigned nbytes, input bit rand_sbf, input int unsigned first_hold);
        int unsigned h;
        for (int i = 0; i < int'(nbytes); i++) begin
            if (i == 0)                                  h = first_hold;
            else if (rand_sbf && $urandom_range(0, 3) == 0) h = $urandom_range(1, 12);
            else                                         h = 0;
            read_byte(h);
        end
    endtask

    task automatic check_done();
        exp_sd++;
        check("sd_count", 64'(sd_count), 64'(exp_sd));
        check("idle_after_send", 64'(current_state), 64'(ST_IDLE));
        check("trd_cleared", 64'(trd), 64'd0);
        check("cd_cleared", 64'(cd), 64'd0);
        check("bytes_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        rd_if.req = 1'b0;
        rd_if.sbf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 64'(current_state), 64'(ST_IDLE));
        check("rst_adc", 64'(adc_data), 64'd0);
        check("rst_flags", 64'({trd, cd, rd_if.rdy, rd_if.sd}), 64'd0);
        check("rst_dat", 64'(rd_if.dat), 64'd0);
        check("rst_trigtm", 64'(trigtm), 64'd0);
        reset = 1'b1;

        // Basic capture at cycle 2, plain read-out.
        run_capture(8'd2);
        read_n(32, 1'b0, 0);
        check_done();

        // Late start: crossing at 200 falls inside pre-fill; first byte leads with a 10-cycle stall.
        run_capture(8'd195);
        read_n(32, 1'b1, 10);
        check_done();

        // Abort in CACHED after 5 bytes.
        run_capture(8'($urandom_range(0, 255)));
        read_n(5, 1'b1, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_state", 64'(current_state), 64'(ST_IDLE));
        check("abort_flags", 64'({trd, cd, rd_if.rdy, rd_if.sd}), 64'd0);
        check("abort_adc", 64'(adc_data), 64'd0);
        check("abort_trigtm", 64'(trigtm), 64'd0);
        exp_q.delete();
        trig_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Fresh capture after abort, random start and backpressure.
        run_capture(8'($urandom_range(0, 255)));
        read_n(32, 1'b1, $urandom_range(0, 6));
        check_done();

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
